// File: rtl/or2_pulse_sequencer.sv
// or2_pulse_sequencer: queued scheduler driving a toggle-encoded RSFQ OR2 gate and sampling its output.
// Define OR2_SEQ_CHECK_EN to enable res_err, spurious-toggle detection and err_cnt.
module or2_pulse_sequencer #(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int CLK2Q_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic       op_a,
  input  logic       op_b,
  output logic       gate_a,
  output logic       gate_b,
  output logic       gate_clk,
  input  logic       gate_q,
  output logic       res_valid,
  output logic       res_q,
  output logic       res_err,
  output logic       busy,
  output logic [7:0] err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int MX = SETUP_CYC > CLK2Q_CYC ? SETUP_CYC : CLK2Q_CYC;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, SETUP, WAIT_Q, REPORT} state_t;
  state_t state_q, state_d;
  logic [1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic gate_a_q, gate_a_d, gate_b_q, gate_b_d, gate_clk_q, gate_clk_d;
  logic q_ref_q, q_ref_d, res_valid_q, res_valid_d, res_q_q, res_q_d;
  logic full, empty, push, pop, sample, spur;
  logic [1:0] head;
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty  = wr_q == rd_q;
  assign push   = op_valid && !full;
  assign pop    = !empty && (state_q == IDLE || state_q == REPORT);
  assign head   = mem_q[rd_q[AW-1:0]];
  assign sample = state_q == WAIT_Q && cnt_q == CW'(1);
  // Outside WAIT_Q the gate must be quiet; any output toggle there is spurious.
  assign spur   = state_q != WAIT_Q && gate_q != q_ref_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gate_a_d    = gate_a_q;
    gate_b_d    = gate_b_q;
    gate_clk_d  = gate_clk_q;
    q_ref_d     = spur ? gate_q : q_ref_q;
    res_valid_d = res_valid_q;
    res_q_d     = res_q_q;
    wr_d        = push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d        = pop ? rd_q + (AW+1)'(1) : rd_q;
    case (state_q)
      IDLE, REPORT: begin
        res_valid_d = 1'b0;
        state_d     = pop ? SETUP : IDLE;
        gate_a_d    = gate_a_q ^ (pop & head[1]);
        gate_b_d    = gate_b_q ^ (pop & head[0]);
        cnt_d       = pop ? CW'(SETUP_CYC) : cnt_q;
      end
      SETUP: begin
        state_d    = cnt_q == CW'(1) ? WAIT_Q : SETUP;
        gate_clk_d = gate_clk_q ^ (cnt_q == CW'(1));
        cnt_d      = cnt_q == CW'(1) ? CW'(CLK2Q_CYC) : cnt_q - CW'(1);
      end
      WAIT_Q: begin
        state_d     = sample ? REPORT : WAIT_Q;
        cnt_d       = sample ? cnt_q : cnt_q - CW'(1);
        res_q_d     = sample ? gate_q ^ q_ref_q : res_q_q;
        q_ref_d     = sample ? gate_q : q_ref_q;
        res_valid_d = sample;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      gate_clk_q  <= 1'b0;
      q_ref_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_q_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      gate_clk_q  <= gate_clk_d;
      q_ref_q     <= q_ref_d;
      res_valid_q <= res_valid_d;
      res_q_q     <= res_q_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {op_a, op_b};
  end
`ifdef OR2_SEQ_CHECK_EN
  logic [1:0] cur_q, cur_d;
  logic res_err_q, res_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  always_comb begin
    cur_d     = pop ? head : cur_q;
    res_err_d = sample ? (gate_q ^ q_ref_q) ^ (cur_q[1] | cur_q[0]) : res_err_q;
    err_cnt_d = ((sample && res_err_d) || spur) && err_cnt_q != 8'hff ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q     <= '0;
      res_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      cur_q     <= cur_d;
      res_err_q <= res_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign res_err = res_err_q;
  assign err_cnt = err_cnt_q;
`else
  assign res_err = 1'b0;
  assign err_cnt = '0;
`endif
  assign op_ready  = !full;
  assign busy      = state_q != IDLE || !empty;
  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign gate_clk  = gate_clk_q;
  assign res_valid = res_valid_q;
  assign res_q     = res_q_q;
endmodule
